// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard-controller state encoding and the RV32
// opcode constants also used by the main decoder.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_LU_STALL = 2'd2,
        ST_MEM_WAIT = 2'd3
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // Instruction formats that carry a real rs2 operand (R-type, store, branch).
    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_R) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_lu_detect.sv
// Combinational load-use compare between the ID instruction and a lw in ID/EX;
// kept standalone so the forwarding unit can reuse it.
module lu_detect
    import pipe_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic       memread_i,
    input  logic [4:0] rd_i,
    output logic       hazard_o
);

    logic rs1_hit;
    logic rs2_hit;

    // An all-zero opcode is the bubble pattern and reads no registers.
    assign rs1_hit  = (opcode_i != 7'b0000000) && (rd_i == rs1_i);
    assign rs2_hit  = uses_rs2(opcode_i) && (rd_i == rs2_i);
    assign hazard_o = memread_i && (rd_i != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, branch flush and the data
// memory wait freeze. Define HAZARD_PERF_EN to add the stall/flush perf counters.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [6:0]       ifid_opcode_i,
    input  logic [4:0]       ifid_rs1_i,
    input  logic [4:0]       ifid_rs2_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rd_i,
    input  logic             branch_taken_i,
    input  logic             exmem_memread_i,
    input  logic             exmem_memwrite_i,
    input  logic             dmem_ack_i,
    output logic             noop_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             pipe_stall_o,
    output logic             dmem_req_o,
    output logic             err_o,
    output state_t           dbg_state_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
    logic              lu;
    logic              ma;
    logic              hold;
    state_t            run_next;

    lu_detect u_lu_detect (
        .opcode_i  (ifid_opcode_i),
        .rs1_i     (ifid_rs1_i),
        .rs2_i     (ifid_rs2_i),
        .memread_i (idex_memread_i),
        .rd_i      (idex_rd_i),
        .hazard_o  (lu)
    );

    assign ma       = exmem_memread_i || exmem_memwrite_i;
    assign hold     = ma && !dmem_ack_i;
    assign run_next = start_i ? ST_RUN : ST_IDLE;

    always_comb begin
        noop_o       = 1'b0;
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
        ifid_flush_o = 1'b0;
        pipe_stall_o = 1'b0;
        dmem_req_o   = 1'b0;
        state_d      = state_q;
        wait_d       = '0;
        err_d        = err_q;
        case (state_q)
            ST_IDLE: begin
                noop_o = 1'b1;
                if (start_i) state_d = ST_RUN;
            end
            default: begin
                dmem_req_o = (state_q == ST_MEM_WAIT) || ma;
                if (hold) begin
                    // Frozen cycle: a pending stop request waits for the ack.
                    pipe_stall_o = 1'b1;
                    state_d      = ST_MEM_WAIT;
                    if (state_q == ST_MEM_WAIT) begin
                        wait_d = (wait_q == WAIT_W'(MEM_TIMEOUT)) ? wait_q : wait_q + WAIT_W'(1);
                        if (int'(wait_q) + 1 >= MEM_TIMEOUT) err_d = 1'b1;
                    end
                end else if (lu) begin
                    noop_o  = 1'b1;
                    state_d = (state_q == ST_RUN && start_i) ? ST_LU_STALL : run_next;
                end else if (branch_taken_i) begin
                    ifid_flush_o = 1'b1;
                    pc_write_o   = 1'b1;
                    ifid_write_o = 1'b1;
                    state_d      = run_next;
                end else begin
                    pc_write_o   = 1'b1;
                    ifid_write_o = 1'b1;
                    state_d      = run_next;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    assign err_o       = err_q;
    assign dbg_state_o = state_q;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic             stall_ev;

    assign stall_ev = (state_q != ST_IDLE) && (lu || pipe_stall_o);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_ev && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (ifid_flush_o && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard scenarios followed by random
// traffic, every cycle compared against a cycle-level reference of the rules.
module tb_pipeline_hazard_ctrl;
    import pipe_pkg::*;

    localparam int TO    = 4;
    localparam int CNT_W = 32;

    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_I   = 7'b0010011;
    localparam logic [6:0] T_LW  = 7'b0000011;
    localparam logic [6:0] T_SW  = 7'b0100011;
    localparam logic [6:0] T_BEQ = 7'b1100011;

    logic       clk = 1'b0;
    logic       rst, start, idex_mr, br, emr, emw, ack;
    logic [6:0] opc;
    logic [4:0] rs1, rs2, rd;
    logic       noop, pc_we, ifid_we, flush, stall, req, err;
    state_t     dbg_state;
`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: running flag, "just bubbled" flag, in-wait flag, wait count, error.
    bit m_on, m_bub, m_wait, m_err;
    int m_wcnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .ifid_opcode_i    (opc),
        .ifid_rs1_i       (rs1),
        .ifid_rs2_i       (rs2),
        .idex_memread_i   (idex_mr),
        .idex_rd_i        (rd),
        .branch_taken_i   (br),
        .exmem_memread_i  (emr),
        .exmem_memwrite_i (emw),
        .dmem_ack_i       (ack),
        .noop_o           (noop),
        .pc_write_o       (pc_we),
        .ifid_write_o     (ifid_we),
        .ifid_flush_o     (flush),
        .pipe_stall_o     (stall),
        .dmem_req_o       (req),
        .err_o            (err),
        .dbg_state_o      (dbg_state)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt_o      (stall_cnt),
        .flush_cnt_o      (flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic bit lu_ref(input logic [6:0] op, input logic [4:0] a, input logic [4:0] b,
                                  input logic mr, input logic [4:0] d);
        bit reads_a, reads_b;
        reads_a = (op != 7'd0);
        reads_b = (op == T_R) || (op == T_SW) || (op == T_BEQ);
        return mr && (d != 0) && ((reads_a && d == a) || (reads_b && d == b));
    endfunction

    task automatic set_id(input logic [6:0] op, input logic [4:0] a, input logic [4:0] b,
                          input logic mr, input logic [4:0] d, input logic take);
        opc = op; rs1 = a; rs2 = b; idex_mr = mr; rd = d; br = take;
    endtask

    task automatic set_mem(input logic r, input logic w, input logic k);
        emr = r; emw = w; ack = k;
    endtask

    // One clock: compare at negedge, advance the reference at the posedge.
    task automatic tick();
        bit e_noop, e_pc, e_ifw, e_fl, e_st, e_req, hold, lu, chk_ifw;
        bit n_on, n_bub, n_wait, n_err;
        int n_wcnt;
        @(negedge clk);
        hold = (emr || emw) && !ack;
        lu   = lu_ref(opc, rs1, rs2, idex_mr, rd);
        e_noop = 0; e_pc = 0; e_ifw = 0; e_fl = 0; e_st = 0; e_req = 0; chk_ifw = 1;
        if (!m_on) e_noop = 1;
        else begin
            e_req = m_wait || emr || emw;
            if (hold) e_st = 1;
            else if (lu) e_noop = 1;
            else if (br) begin e_fl = 1; e_pc = 1; chk_ifw = 0; end
            else begin e_pc = 1; e_ifw = 1; end
        end
        chk("noop", noop, e_noop);
        chk("pc_write", pc_we, e_pc);
        if (chk_ifw) chk("ifid_write", ifid_we, e_ifw);
        chk("ifid_flush", flush, e_fl);
        chk("pipe_stall", stall, e_st);
        chk("dmem_req", req, e_req);
        chk("err", err, m_err);
        n_on = m_on; n_bub = 0; n_wait = m_wait; n_err = m_err; n_wcnt = m_wcnt;
        if (rst) begin
            n_on = 0; n_wait = 0; n_err = 0; n_wcnt = 0;
        end else if (!m_on) begin
            n_on = start;
        end else if (hold) begin
            if (m_wait) begin
                n_wcnt = m_wcnt + 1;
                if (n_wcnt >= TO) n_err = 1;
            end else n_wcnt = 0;
            n_wait = 1;
        end else begin
            n_bub  = lu && !m_bub && !m_wait && start;
            n_on   = start;
            n_wait = 0;
            n_wcnt = 0;
        end
        @(posedge clk);
        m_on = n_on; m_bub = n_bub; m_wait = n_wait; m_err = n_err; m_wcnt = n_wcnt;
        #1;
    endtask

    initial begin
        rst = 1; start = 0;
        set_id(7'd0, 0, 0, 0, 0, 0);
        set_mem(0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        m_on = 0; m_bub = 0; m_wait = 0; m_err = 0; m_wcnt = 0;
        @(negedge clk);
        chk("rst_state", dbg_state, ST_IDLE);
        chk("rst_noop", noop, 1);
        chk("rst_pc_write", pc_we, 0);
        chk("rst_req", req, 0);
        chk("rst_err", err, 0);
        @(posedge clk); #1;

        // Start at the third cycle after reset.
        repeat (2) tick();
        start = 1;
        tick();
        tick();

        // lw x5 / add x6,x5,x7, then x0 destination, then addi rs1 match with rs2=5.
        set_id(T_R, 5, 7, 1, 5, 0); tick();
        set_id(T_R, 6, 7, 0, 0, 0); tick();
        set_id(T_R, 0, 7, 1, 0, 0); tick();
        set_id(T_I, 5, 5, 1, 5, 0); tick();
        set_id(T_I, 6, 5, 0, 0, 0); tick();
        set_id(T_I, 7, 5, 1, 5, 0); tick();
        set_id(7'd0, 5, 5, 1, 5, 0); tick();
        set_id(T_SW, 1, 5, 1, 5, 0); tick();
        set_id(T_LW, 1, 2, 0, 0, 0); tick();

        // Branch taken alone, then taken together with a load-use hazard.
        set_id(T_BEQ, 1, 2, 0, 0, 1); tick();
        set_id(T_R, 1, 2, 0, 0, 0); tick();
        set_id(T_BEQ, 5, 2, 1, 5, 1); tick();
        set_id(T_BEQ, 5, 2, 0, 0, 1); tick();
        set_id(T_R, 1, 2, 0, 0, 0); tick();

        // sw waiting three cycles for ack, then a zero-wait access.
        set_mem(0, 1, 0); repeat (3) tick();
        set_mem(0, 1, 1); tick();
        set_mem(0, 0, 0); tick();
        set_mem(1, 0, 1); tick();
        set_mem(0, 0, 0); tick();

        // Timeout with no ack; err must stick, then reset clears everything.
        set_mem(0, 1, 0); repeat (7) tick();
        @(negedge clk);
        chk("err_sticky", err, 1);
        chk("wait_req", req, 1);
        @(posedge clk); #1;
        rst = 1; tick();
        rst = 0; start = 0; tick();
        @(negedge clk);
        chk("post_rst_req", req, 0);
        chk("post_rst_err", err, 0);
        @(posedge clk); #1;
        set_mem(0, 0, 0);
        start = 1; tick();

        // Random traffic; EX/MEM stays put while the pipe is frozen.
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 19) != 0);
            case ($urandom_range(0, 5))
                0: opc = T_R;
                1: opc = T_I;
                2: opc = T_LW;
                3: opc = T_SW;
                4: opc = T_BEQ;
                default: opc = 7'd0;
            endcase
            rs1     = 5'($urandom_range(0, 7));
            rs2     = 5'($urandom_range(0, 7));
            rd      = 5'($urandom_range(0, 7));
            idex_mr = ($urandom_range(0, 9) < 3);
            br      = ($urandom_range(0, 9) < 2);
            ack     = ($urandom_range(0, 9) < 4);
            if (!m_wait) begin
                emr = ($urandom_range(0, 9) < 1);
                emw = !emr && ($urandom_range(0, 9) < 1);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Sequencing controller for the 5-stage RV32 subset pipeline (add/sub/and/or/xor/sll/mul, addi/srai, lw, sw, beq). It generates the `NoOp` bubble request consumed by the main decoder, the PC and IF/ID write enables, and the IF/ID flush. It also runs the data-memory wait handshake that freezes the whole pipeline while a lw/sw is outstanding. It sits beside the ID stage and watches ID/EX and EX/MEM state.

## Interface
Parameters:
- `MEM_TIMEOUT`, 16: maximum cycles in MEM_WAIT before `err_o` is raised.
- `CNT_W`, 32: perf counter width.

Ports:
- `clk_i` in 1: the single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `start_i` in 1: CPU run enable.
- `ifid_opcode_i` in 7: opcode of the instruction in ID.
- `ifid_rs1_i` in 5: rs1 of the instruction in ID.
- `ifid_rs2_i` in 5: rs2 of the instruction in ID.
- `idex_memread_i` in 1: ID/EX holds a lw.
- `idex_rd_i` in 5: destination register of the ID/EX instruction.
- `branch_taken_i` in 1: beq in ID resolved as taken.
- `exmem_memread_i` in 1: EX/MEM holds a lw.
- `exmem_memwrite_i` in 1: EX/MEM holds a sw.
- `dmem_ack_i` in 1: data memory completes the current access.
- `noop_o` out 1: drives decoder `NoOp`; forces zero control into ID/EX.
- `pc_write_o` out 1: PC update enable.
- `ifid_write_o` out 1: IF/ID write enable.
- `ifid_flush_o` out 1: zeroes IF/ID on the next edge.
- `pipe_stall_o` out 1: freezes PC and all pipeline registers.
- `dmem_req_o` out 1: data memory access request.
- `err_o` out 1: sticky memory timeout flag.
- `stall_cnt_o` out CNT_W: load-use plus memory-wait stall cycles (only with the macro).
- `flush_cnt_o` out CNT_W: branch flush count (only with the macro).

## Operation
- States: IDLE, RUN, LU_STALL, MEM_WAIT.
- IDLE:
  - Outputs: `noop_o`=1, `pc_write_o`=0, `ifid_write_o`=0, all others 0.
  - `start_i`=1 sampled at an edge → RUN.
- Load-use hazard (`lu`) = `idex_memread_i` && `idex_rd_i`≠0 && (`idex_rd_i`==`ifid_rs1_i` || (rs2-user && `idex_rd_i`==`ifid_rs2_i`)).
  - rs2-user opcodes: 0110011, 0100011, 1100011.
  - rs1 is compared for every opcode except 0000000.
- Memory access (`ma`) = `exmem_memread_i` || `exmem_memwrite_i`.
- `dmem_req_o` = `ma` while in RUN, LU_STALL or MEM_WAIT.
- Priority each cycle in RUN: memory wait > load-use > branch flush.
  - `ma` && !`dmem_ack_i`: `pipe_stall_o`=1 and `pc_write_o`=0. Next state MEM_WAIT. No other action this cycle.
  - else `lu`: `noop_o`=1, `pc_write_o`=0, `ifid_write_o`=0. Next state LU_STALL. A simultaneous `branch_taken_i` is ignored; the beq is re-evaluated after the stall.
  - else `branch_taken_i`: `ifid_flush_o`=1, `pc_write_o`=1.
  - else: `pc_write_o`=`ifid_write_o`=1, `noop_o`=0.
- LU_STALL:
  - Lasts exactly one cycle.
  - Outputs are evaluated as in RUN; the lw has advanced, so `lu` is normally 0.
  - Next state RUN, or MEM_WAIT if the memory-wait condition holds.
- MEM_WAIT:
  - `pipe_stall_o`=1 and `dmem_req_o`=1 while !`dmem_ack_i`.
  - On the ack cycle, `pipe_stall_o`=0 and RUN rules apply combinationally; next state RUN.
  - A wait counter increments each MEM_WAIT cycle. Reaching `MEM_TIMEOUT` sets `err_o` (sticky until reset); the state remains MEM_WAIT.
- `start_i` deassert in RUN: finish the current cycle, then go to IDLE. A MEM_WAIT in progress completes first.

## Timing
- Outputs are Mealy: combinational from state plus inputs, with zero-cycle latency to the pipeline enables.
- State, wait counter, `err_o` and perf counters are registered.
- Reset values:
  - State IDLE.
  - `noop_o`=1.
  - `pc_write_o`, `ifid_write_o`, `ifid_flush_o`, `pipe_stall_o`, `dmem_req_o`, `err_o` = 0.
  - Counters 0.
- A reset asserted mid MEM_WAIT drops `dmem_req_o` in the cycle after the reset edge.
- An ack in the same cycle `ma` first appears gives a zero-wait access: no stall and no MEM_WAIT entry.
- The load-use bubble is exactly 1 cycle. A memory wait costs N cycles, where N is the number of cycles before ack.

## Configuration
- `HAZARD_PERF_EN` defined:
  - `stall_cnt_o` increments on every cycle with `lu`, or with `pipe_stall_o`=1 in RUN/LU_STALL/MEM_WAIT.
  - `flush_cnt_o` increments on every `ifid_flush_o` cycle.
  - Both counters saturate at all-ones.
- `HAZARD_PERF_EN` undefined: the counter ports and logic are absent.

## Structure
- Shared package `pipe_pkg` holds:
  - the state enum;
  - opcode constants OP_R, OP_I, OP_LW, OP_SW, OP_BEQ, which are also used by the main decoder.
- One sub-module `lu_detect`: the combinational load-use compare, reusable by the forwarding unit.

## Test plan
- Reset, then `start_i`=1 at cycle 3: `noop_o`=1 through cycle 3, RUN from cycle 4, `pc_write_o`=1.
- lw x5 in ID/EX with add x6,x5,x7 in ID: exactly 1 cycle of `noop_o`=1, `pc_write_o`=0, `ifid_write_o`=0, then normal flow. The same case with rd=x0 produces no stall.
- lw x5 in ID/EX with addi x6,x5,1 in ID and `ifid_rs2_i`=5: one stall, caused by the rs1 match.
- beq taken with no hazard: one cycle of `ifid_flush_o`=1 and `pc_write_o`=1. beq taken together with `lu`: stall first, flush on the following cycle.
- sw in EX/MEM, ack after 3 cycles: `pipe_stall_o`=1 for 3 cycles, `dmem_req_o`=1 for 4, then RUN. An ack on the first cycle causes no stall.
- `MEM_TIMEOUT`=4 with no ack: `err_o`=1 after 4 MEM_WAIT cycles and stays set. Reset clears it, returns to IDLE and drops `dmem_req_o`.
